// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: access-size codes, FSM states, bus widths.
package lsu_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int BE_W       = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {S_RUN, S_WAIT} lsu_state_t;
endpackage

// File: rtl/mem_load_ext.sv
// Load alignment and sign/zero extension; purely combinational, no backpressure.
module mem_load_ext
    import lsu_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            offs,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offs)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offs[1] ? rdata[31:16] : rdata[15:0];
    end

    // Unlisted encodings fall through to a full-word load.
    always_comb begin
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: EXE/MEM and MEM/WB registers, data-memory req/ack access, one cycle per instruction at zero wait.
// Stalls upstream while a request is unacked; optional MEM_MISALIGN_CHK_EN flags misaligned accesses instead of issuing them.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic              EXE_MEM_DM_read,
    input  logic              EXE_MEM_DM_write,
    input  logic              EXE_MEM_rd_sel,
    input  logic              EXE_MEM_reg_write,
    input  logic [DATA_W-1:0] ALU_o,
    input  logic [DATA_W-1:0] Mux3_ALU,
    input  logic [2:0]        EXE_MEM_function_3,
    input  logic [4:0]        EXE_MEM_rd_addr,
    output logic              stall_o,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [BE_W-1:0]   dm_be,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic [DATA_W-1:0] MEM_rd_data,
    output logic [4:0]        MEM_rd_addr,
    output logic              MEM_reg_write,
    output logic              WB_valid,
    output logic              WB_reg_write,
    output logic [4:0]        WB_rd_addr,
    output logic [DATA_W-1:0] WB_rd_data,
    output logic [CNT_W-1:0]  stall_cnt
`ifdef MEM_MISALIGN_CHK_EN
    ,
    output logic              misalign_o
`endif
);
    logic              ex_valid, ex_read, ex_write, ex_rd_sel, ex_reg_write;
    logic [DATA_W-1:0] ex_alu, ex_sdata;
    logic [2:0]        ex_f3;
    logic [4:0]        ex_rd;
    lsu_state_t        state, state_nxt;
    logic              access, misal, mem_op, misal_q;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata, load_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_read      <= 1'b0;
            ex_write     <= 1'b0;
            ex_rd_sel    <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_alu       <= '0;
            ex_sdata     <= '0;
            ex_f3        <= '0;
            ex_rd        <= '0;
        end else if (!stall_o) begin
            ex_valid     <= exe_valid;
            ex_read      <= EXE_MEM_DM_read;
            ex_write     <= EXE_MEM_DM_write;
            ex_rd_sel    <= EXE_MEM_rd_sel;
            ex_reg_write <= EXE_MEM_reg_write;
            ex_alu       <= ALU_o;
            ex_sdata     <= Mux3_ALU;
            ex_f3        <= EXE_MEM_function_3;
            ex_rd        <= EXE_MEM_rd_addr;
        end
    end

    assign access = ex_valid & (ex_read | ex_write);

`ifdef MEM_MISALIGN_CHK_EN
    assign misal = access & ((((ex_f3 == F3_LH) || (ex_f3 == F3_LHU)) & ex_alu[0])
                           | ((ex_f3 == F3_LW) & (ex_alu[1:0] != 2'b00)));
`else
    assign misal = 1'b0;
`endif

    assign mem_op = access & ~misal;

    // Stores take priority if both read and write are flagged.
    always_comb begin
        be    = '1;
        wdata = ex_sdata;
        if (ex_write) begin
            case (ex_f3)
                F3_SB: begin
                    be    = BE_W'(1) << ex_alu[1:0];
                    wdata = {4{ex_sdata[7:0]}};
                end
                F3_SH: begin
                    be    = ex_alu[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{ex_sdata[15:0]}};
                end
                default: be = '1;
            endcase
        end
    end

    mem_load_ext u_load_ext (
        .rdata  (dm_rdata),
        .offs   (ex_alu[1:0]),
        .funct3 (ex_f3),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (mem_op && !dm_ack) state_nxt = S_WAIT;
            S_WAIT:  if (dm_ack || !mem_op) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    // Request fields come straight from EXE/MEM, which is frozen while waiting, so they stay stable until ack.
    always_comb begin
        dm_req   = mem_op;
        dm_we    = mem_op & ex_write;
        dm_be    = mem_op ? be : '0;
        dm_wdata = (mem_op & ex_write) ? wdata : '0;
        dm_addr  = {ex_alu[DATA_W-1:2], 2'b00};
        stall_o  = mem_op & ~dm_ack;
    end

    assign MEM_rd_data   = ex_alu;
    assign MEM_rd_addr   = ex_rd;
    assign MEM_reg_write = ex_valid & ex_reg_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_valid     <= 1'b0;
            WB_reg_write <= 1'b0;
            WB_rd_addr   <= '0;
            WB_rd_data   <= '0;
            misal_q      <= 1'b0;
        end else if (!stall_o) begin
            WB_valid     <= ex_valid;
            WB_reg_write <= ex_valid & ex_reg_write & ~ex_write & ~misal;
            WB_rd_addr   <= ex_rd;
            WB_rd_data   <= ex_rd_sel ? load_data : ex_alu;
            misal_q      <= misal;
        end else begin
            WB_valid     <= 1'b0;
            WB_reg_write <= 1'b0;
            misal_q      <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          stall_cnt <= '0;
        else if (stall_o && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end

`ifdef MEM_MISALIGN_CHK_EN
    assign misalign_o = misal_q;
`else
    logic unused_misal;
    assign unused_misal = misal_q;
`endif
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios plus a randomized instruction stream against a behavioural model.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid, dm_read, dm_write, rd_sel, reg_write;
    logic [31:0] alu_o, mux3_alu;
    logic [2:0]  f3;
    logic [4:0]  rd_addr;
    logic        stall_o, dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic [31:0] mem_rd_data, wb_rd_data;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        mem_reg_write, wb_valid, wb_reg_write;
    logic [15:0] stall_cnt;
`ifdef MEM_MISALIGN_CHK_EN
    logic        misalign_o;
`endif

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    typedef struct {
        logic        v, rd, wr, rs, rw;
        logic [31:0] alu, sd;
        logic [2:0]  f3;
        logic [4:0]  rdad;
        int          k;
    } ins_t;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst), .exe_valid(exe_valid),
        .EXE_MEM_DM_read(dm_read), .EXE_MEM_DM_write(dm_write),
        .EXE_MEM_rd_sel(rd_sel), .EXE_MEM_reg_write(reg_write),
        .ALU_o(alu_o), .Mux3_ALU(mux3_alu), .EXE_MEM_function_3(f3),
        .EXE_MEM_rd_addr(rd_addr), .stall_o(stall_o), .dm_req(dm_req),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .MEM_rd_data(mem_rd_data),
        .MEM_rd_addr(mem_rd_addr), .MEM_reg_write(mem_reg_write),
        .WB_valid(wb_valid), .WB_reg_write(wb_reg_write), .WB_rd_addr(wb_rd_addr),
        .WB_rd_data(wb_rd_data), .stall_cnt(stall_cnt)
`ifdef MEM_MISALIGN_CHK_EN
        , .misalign_o(misalign_o)
`endif
    );

    function automatic ins_t mk(input logic v, rd, wr, rs, rw, input logic [31:0] alu, sd,
                                input logic [2:0] fn, input logic [4:0] rdad, input int k);
        ins_t x;
        x.v = v; x.rd = rd; x.wr = wr; x.rs = rs; x.rw = rw;
        x.alu = alu; x.sd = sd; x.f3 = fn; x.rdad = rdad; x.k = k;
        return x;
    endfunction

    task automatic drive(input ins_t x);
        exe_valid = x.v; dm_read = x.rd; dm_write = x.wr; rd_sel = x.rs; reg_write = x.rw;
        alu_o = x.alu; mux3_alu = x.sd; f3 = x.f3; rd_addr = x.rdad;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: byte lanes and replication written as plain arithmetic.
    function automatic logic [3:0] exp_be(input logic st, input logic [2:0] fn, input logic [31:0] a);
        if (!st) return 4'hF;
        case (fn)
            3'd0:    return 4'(1 << (a % 4));
            3'd1:    return ((a % 4) >= 2) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] fn, input logic [31:0] d);
        case (fn)
            3'd0:    return (d & 32'hFF) * 32'h01010101;
            3'd1:    return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] fn, input logic [31:0] a, r);
        logic [31:0] b, h;
        b = (r >> (8 * (a % 4))) & 32'hFF;
        h = (r >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (fn)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            default: return r;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
        drive(mk(1, 1, 0, 1, 1, 32'h44, 0, 3'd2, 5'd4, 0));
        step(); #2;
        tests++; if (dm_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", dm_req); end
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", stall_o); end
        tests++; if (dm_be !== 4'h0) begin fails++; $display("FAIL reset_be got %h exp 0", dm_be); end
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
        tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
        tests++; if (mem_rd_data !== 32'h0 || mem_reg_write !== 1'b0 || wb_rd_data !== 32'h0)
            begin fails++; $display("FAIL reset_regs got %h/%b/%h exp 0", mem_rd_data, mem_reg_write, wb_rd_data); end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_wait_states();
        drive(mk(1, 1, 0, 1, 1, 32'h200, 0, 3'd2, 5'd7, 0));
        dm_ack = 1'b0;
        step();
        drive(mk(1, 0, 0, 0, 1, 32'h55, 0, 3'd0, 5'd9, 0));
        for (int w = 0; w < 3; w++) begin
            #2;
            tests++; if (stall_o !== 1'b1 || dm_req !== 1'b1)
                begin fails++; $display("FAIL wait_stall[%0d] got %b/%b exp 1/1", w, stall_o, dm_req); end
            tests++; if (dm_addr !== 32'h200 || dm_be !== 4'hF || dm_we !== 1'b0)
                begin fails++; $display("FAIL wait_fields[%0d] got %h/%h/%b exp 200/f/0", w, dm_addr, dm_be, dm_we); end
            step();
            tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL wait_bubble[%0d] got %b exp 0", w, wb_valid); end
        end
        exp_cnt += 3;
        dm_ack = 1'b1; dm_rdata = 32'h12345678;
        #2;
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL wait_ack_stall got %b exp 0", stall_o); end
        tests++; if (stall_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL wait_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
        step();
        dm_ack = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tests++; if (wb_valid !== 1'b1 || wb_rd_data !== 32'h12345678 || wb_rd_addr !== 5'd7 || wb_reg_write !== 1'b1)
            begin fails++; $display("FAIL wait_wb got %b/%h/%0d/%b exp 1/12345678/7/1", wb_valid, wb_rd_data, wb_rd_addr, wb_reg_write); end
        tests++; if (mem_rd_data !== 32'h55 || mem_rd_addr !== 5'd9 || mem_reg_write !== 1'b1)
            begin fails++; $display("FAIL wait_next_captured got %h/%0d/%b exp 55/9/1", mem_rd_data, mem_rd_addr, mem_reg_write); end
        step();
        tests++; if (wb_valid !== 1'b1 || wb_rd_data !== 32'h55)
            begin fails++; $display("FAIL wait_next_wb got %b/%h exp 1/55", wb_valid, wb_rd_data); end
    endtask

    task automatic test_store();
        drive(mk(1, 0, 1, 0, 1, 32'h100, 32'hDEADBEEF, 3'd2, 5'd3, 0));
        dm_ack = 1'b1;
        step();
        drive(mk(1, 0, 1, 0, 1, 32'h103, 32'h123456A5, 3'd0, 5'd3, 0));
        #2;
        tests++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || stall_o !== 1'b0)
            begin fails++; $display("FAIL sw_ctrl got %b/%b/%b exp 1/1/0", dm_req, dm_we, stall_o); end
        tests++; if (dm_be !== 4'hF || dm_wdata !== 32'hDEADBEEF || dm_addr !== 32'h100)
            begin fails++; $display("FAIL sw_fields got %h/%h/%h exp f/deadbeef/100", dm_be, dm_wdata, dm_addr); end
        step();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        tests++; if (dm_be !== 4'h8 || dm_wdata !== 32'hA5A5A5A5 || dm_addr !== 32'h100)
            begin fails++; $display("FAIL sb_fields got %h/%h/%h exp 8/a5a5a5a5/100", dm_be, dm_wdata, dm_addr); end
        tests++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0)
            begin fails++; $display("FAIL sw_wb got %b/%b exp 1/0", wb_valid, wb_reg_write); end
        step();
        dm_ack = 1'b0;
        tests++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || stall_cnt !== 16'(exp_cnt))
            begin fails++; $display("FAIL sb_wb got %b/%b/%0d exp 1/0/%0d", wb_valid, wb_reg_write, stall_cnt, exp_cnt); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  fns [3];
        logic [31:0] exps [3];
        fns[0] = 3'd0; fns[1] = 3'd4; fns[2] = 3'd5;
        exps[0] = 32'hFFFFFF80; exps[1] = 32'h00000080; exps[2] = 32'h00000080;
        dm_ack = 1'b1; dm_rdata = 32'h0080FF00;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 3) drive(mk(1, 1, 0, 1, 1, 32'h102, 0, fns[i], 5'(i + 1), 0));
            else       drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            #2;
            if (i >= 2) begin
                tests++; if (wb_rd_data !== exps[i-2] || wb_valid !== 1'b1 || wb_rd_addr !== 5'(i - 1))
                    begin fails++; $display("FAIL load_ext[%0d] got %h/%b/%0d exp %h/1/%0d", i - 2, wb_rd_data, wb_valid, wb_rd_addr, exps[i-2], i - 1); end
            end
        end
        dm_ack = 1'b0;
    endtask

    task automatic test_random();
        ins_t q [40];
        logic [31:0] rdat, a;
        int sel;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 2);
            a = $urandom;
`ifdef MEM_MISALIGN_CHK_EN
            a[1:0] = 2'b00;
`endif
            if (sel == 0)      q[i] = mk(1, 0, 0, 0, 1'($urandom), $urandom, $urandom, 3'($urandom), 5'($urandom), 0);
            else if (sel == 1) q[i] = mk(1, 1, 0, 1, 1'($urandom), a, $urandom, 3'($urandom), 5'($urandom), $urandom_range(0, 3));
            else               q[i] = mk(1, 0, 1, 0, 1'($urandom), a, $urandom, 3'($urandom_range(0, 2)), 5'($urandom), $urandom_range(0, 3));
        end
        rdat = 32'h0;
        dm_ack = 1'b0;
        drive(q[0]);
        for (int i = 0; i <= 40; i++) begin
            step();
            if (i > 0) begin
                tests++; if (wb_valid !== 1'b1 || wb_rd_addr !== q[i-1].rdad || wb_reg_write !== (q[i-1].rw & ~q[i-1].wr))
                    begin fails++; $display("FAIL rnd_wb_ctl[%0d] got %b/%0d/%b", i - 1, wb_valid, wb_rd_addr, wb_reg_write); end
                tests++; if (wb_rd_data !== (q[i-1].rs ? exp_load(q[i-1].f3, q[i-1].alu, rdat) : q[i-1].alu))
                    begin fails++; $display("FAIL rnd_wb_data[%0d] got %h", i - 1, wb_rd_data); end
            end
            if (i == 40) break;
            if (i < 39) drive(q[i+1]);
            else        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            if (q[i].rd || q[i].wr) begin
                dm_ack = 1'b0;
                for (int w = 0; w < q[i].k; w++) begin
                    #2;
                    tests++; if (stall_o !== 1'b1 || dm_req !== 1'b1 || dm_addr !== (q[i].alu & 32'hFFFFFFFC) || dm_be !== exp_be(q[i].wr, q[i].f3, q[i].alu))
                        begin fails++; $display("FAIL rnd_wait[%0d] got %b/%b/%h/%h", i, stall_o, dm_req, dm_addr, dm_be); end
                    step();
                    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL rnd_bubble[%0d] got %b exp 0", i, wb_valid); end
                end
                exp_cnt += q[i].k;
                rdat = $urandom;
                dm_ack = 1'b1; dm_rdata = rdat;
                #2;
                tests++; if (stall_o !== 1'b0 || dm_req !== 1'b1 || dm_we !== q[i].wr || dm_be !== exp_be(q[i].wr, q[i].f3, q[i].alu))
                    begin fails++; $display("FAIL rnd_ack[%0d] got %b/%b/%b/%h", i, stall_o, dm_req, dm_we, dm_be); end
                if (q[i].wr) begin
                    tests++; if (dm_wdata !== exp_wdata(q[i].f3, q[i].sd))
                        begin fails++; $display("FAIL rnd_wdata[%0d] got %h exp %h", i, dm_wdata, exp_wdata(q[i].f3, q[i].sd)); end
                end
            end else begin
                dm_ack = 1'($urandom); dm_rdata = $urandom;
                #2;
                tests++; if (dm_req !== 1'b0 || stall_o !== 1'b0)
                    begin fails++; $display("FAIL rnd_alu[%0d] got %b/%b exp 0/0", i, dm_req, stall_o); end
            end
        end
        dm_ack = 1'b0;
        tests++; if (stall_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL rnd_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_bubble();
        drive(mk(0, 1, 0, 1, 1, 32'h80, 0, 3'd2, 5'd6, 0));
        dm_ack = 1'b1;
        step();
        #2;
        tests++; if (dm_req !== 1'b0 || stall_o !== 1'b0 || mem_reg_write !== 1'b0)
            begin fails++; $display("FAIL bubble_mem got %b/%b/%b exp 0/0/0", dm_req, stall_o, mem_reg_write); end
        step();
        tests++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || stall_cnt !== 16'(exp_cnt))
            begin fails++; $display("FAIL bubble_wb got %b/%b/%0d exp 0/0/%0d", wb_valid, wb_reg_write, stall_cnt, exp_cnt); end
        dm_ack = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_reset_in_wait();
        drive(mk(1, 1, 0, 1, 1, 32'h300, 0, 3'd2, 5'd2, 0));
        dm_ack = 1'b0;
        step();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL rstw_pre got %b exp 1", stall_o); end
        step();
        rst = 1'b1;
        #1;
        tests++; if (dm_req !== 1'b0 || stall_o !== 1'b0 || stall_cnt !== 16'd0)
            begin fails++; $display("FAIL rstw_async got %b/%b/%0d exp 0/0/0", dm_req, stall_o, stall_cnt); end
        exp_cnt = 0;
        step();
        rst = 1'b0; dm_ack = 1'b1;
        #2;
        tests++; if (dm_req !== 1'b0 || stall_o !== 1'b0)
            begin fails++; $display("FAIL rstw_late_ack got %b/%b exp 0/0", dm_req, stall_o); end
        step();
        dm_ack = 1'b0;
        tests++; if (wb_valid !== 1'b0 || stall_cnt !== 16'd0)
            begin fails++; $display("FAIL rstw_wb got %b/%0d exp 0/0", wb_valid, stall_cnt); end
        drive(mk(1, 1, 0, 1, 1, 32'h10, 0, 3'd2, 5'd8, 0));
        dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
        step();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        tests++; if (stall_o !== 1'b0 || dm_req !== 1'b1)
            begin fails++; $display("FAIL rstw_resume got %b/%b exp 0/1", stall_o, dm_req); end
        step();
        dm_ack = 1'b0;
        tests++; if (wb_valid !== 1'b1 || wb_rd_data !== 32'hCAFEF00D)
            begin fails++; $display("FAIL rstw_resume_wb got %b/%h exp 1/cafef00d", wb_valid, wb_rd_data); end
    endtask

`ifdef MEM_MISALIGN_CHK_EN
    task automatic test_misalign();
        drive(mk(1, 1, 0, 1, 1, 32'h102, 0, 3'd2, 5'd5, 0));
        dm_ack = 1'b0;
        step();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        tests++; if (dm_req !== 1'b0 || stall_o !== 1'b0)
            begin fails++; $display("FAIL mis_req got %b/%b exp 0/0", dm_req, stall_o); end
        step();
        tests++; if (misalign_o !== 1'b1 || wb_reg_write !== 1'b0 || wb_valid !== 1'b1)
            begin fails++; $display("FAIL mis_wb got %b/%b/%b exp 1/0/1", misalign_o, wb_reg_write, wb_valid); end
        step();
        tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL mis_clear got %b exp 0", misalign_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_wait_states();
        test_store();
        test_load_ext();
        test_random();
        test_bubble();
        test_reset_in_wait();
`ifdef MEM_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
